// File: rtl/counter_sequence_checker_if.sv
// Bundle of the checker's sampled inputs and its registered status outputs.
// The stimulus side (master) drives enable and the counter value; the
// checker (slave) reports its reference count, flags and counters back.
interface counter_sequence_checker_if #(
    parameter int WIDTH     = 4,
    parameter int ERR_CNT_W = 8
);
    logic                 enable;
    logic [WIDTH-1:0]     counter_in;
    logic [WIDTH-1:0]     expected;
    logic                 seq_ok;
    logic                 error_pulse;
    logic                 error;
    logic [ERR_CNT_W-1:0] error_count;
    logic [7:0]           wrap_count;
    logic                 terminal;
    logic [1:0]           state;

    modport master (
        output enable, counter_in,
        input  expected, seq_ok, error_pulse, error, error_count,
               wrap_count, terminal, state
    );

    modport slave (
        input  enable, counter_in,
        output expected, seq_ok, error_pulse, error, error_count,
               wrap_count, terminal, state
    );
endinterface

// File: rtl/counter_sequence_checker.sv
// Receive-side checker for a WIDTH-bit up-counter. It runs its own reference
// count from the shared enable/reset, compares every sample of the counter,
// resynchronises after a fault, and reports terminal counts and wraps.
module counter_sequence_checker #(
    parameter int              WIDTH            = 4,
    parameter int              ERR_CNT_W        = 8,
    parameter logic [WIDTH-1:0] TERMINAL        = {WIDTH{1'b1}},
    parameter bit              STOP_ON_TERMINAL = 1'b1
) (
    input  logic                        clock,
    input  logic                        reset,
    counter_sequence_checker_if.slave   bus
);

    localparam logic [1:0] IDLE  = 2'b00;
    localparam logic [1:0] TRACK = 2'b01;
    localparam logic [1:0] FAULT = 2'b10;
    localparam logic [1:0] DONE  = 2'b11;

    logic [1:0]           state_reg,       state_next;
    logic [WIDTH-1:0]     expected_reg,    expected_next;
    logic                 seq_ok_reg,      seq_ok_next;
    logic                 error_pulse_reg, error_pulse_next;
    logic                 error_reg,       error_next;
    logic [ERR_CNT_W-1:0] error_count_reg, error_count_next;
    logic [7:0]           wrap_count_reg,  wrap_count_next;
    logic                 terminal_reg,    terminal_next;

    logic                 sample_match;
    logic [WIDTH-1:0]     enable_inc;

    assign sample_match = (bus.counter_in == expected_reg);
    assign enable_inc   = {{(WIDTH-1){1'b0}}, bus.enable};

    // Compare the current sample against the reference and decide the next
    // state, reference value, flags and counters.
    always_comb begin
        state_next       = state_reg;
        expected_next    = expected_reg;
        seq_ok_next      = seq_ok_reg;
        error_pulse_next = 1'b0;
        error_next       = error_reg;
        error_count_next = error_count_reg;
        wrap_count_next  = wrap_count_reg;
        terminal_next    = 1'b0;

        // DONE freezes everything; pulses simply fall back to 0.
        if (state_reg != DONE) begin
            if (!sample_match) begin
                error_pulse_next = 1'b1;
                error_next       = 1'b1;
                if (error_count_reg != {ERR_CNT_W{1'b1}})
                    error_count_next = error_count_reg + 1'b1;
            end

            case (state_reg)
                IDLE: begin
                    // The reference stays anchored at 0 until counting starts.
                    expected_next = expected_reg + enable_inc;
                    state_next    = bus.enable ? TRACK : IDLE;
                end
                TRACK: begin
                    // Resync from the sample: on a match this equals the
                    // reference, on a mismatch it re-anchors on the counter.
                    expected_next = bus.counter_in + enable_inc;
                    state_next    = sample_match ? TRACK : FAULT;
                    if (sample_match && (bus.counter_in == TERMINAL)) begin
                        terminal_next   = 1'b1;
                        wrap_count_next = wrap_count_reg + 8'd1;
                        if (STOP_ON_TERMINAL)
                            state_next = DONE;
                    end
                end
                FAULT: begin
                    expected_next = bus.counter_in + enable_inc;
                    state_next    = sample_match ? TRACK : FAULT;
                end
                default: begin
                    state_next = state_reg;
                end
            endcase

            seq_ok_next = sample_match &&
                          ((state_next == TRACK) || (state_next == DONE));
        end
    end

    // Register all outputs; reset wins over any event on the same edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg       <= IDLE;
            expected_reg    <= '0;
            seq_ok_reg      <= 1'b0;
            error_pulse_reg <= 1'b0;
            error_reg       <= 1'b0;
            error_count_reg <= '0;
            wrap_count_reg  <= '0;
            terminal_reg    <= 1'b0;
        end else begin
            state_reg       <= state_next;
            expected_reg    <= expected_next;
            seq_ok_reg      <= seq_ok_next;
            error_pulse_reg <= error_pulse_next;
            error_reg       <= error_next;
            error_count_reg <= error_count_next;
            wrap_count_reg  <= wrap_count_next;
            terminal_reg    <= terminal_next;
        end
    end

    assign bus.state       = state_reg;
    assign bus.expected    = expected_reg;
    assign bus.seq_ok      = seq_ok_reg;
    assign bus.error_pulse = error_pulse_reg;
    assign bus.error       = error_reg;
    assign bus.error_count = error_count_reg;
    assign bus.wrap_count  = wrap_count_reg;
    assign bus.terminal    = terminal_reg;

endmodule

// File: tb/tb_counter_sequence_checker.sv
// Bench for counter_sequence_checker: three instances (stop at terminal,
// free-running wrap, 2-bit error counter) share one stimulus stream and are
// each compared every cycle against a behavioural reference model.
module tb_counter_sequence_checker;

    localparam int N = 3;

    logic       clock;
    logic       reset;
    logic       enable;
    logic [3:0] counter_in;

    logic [3:0] obs_expected    [N];
    logic       obs_seq_ok      [N];
    logic       obs_error_pulse [N];
    logic       obs_error       [N];
    logic [7:0] obs_error_count [N];
    logic [7:0] obs_wrap_count  [N];
    logic       obs_terminal    [N];
    logic [1:0] obs_state       [N];

    int stop_p  [N] = '{1, 0, 1};
    int err_max [N] = '{255, 255, 3};

    // Reference model state, one entry per instance.
    int m_state [N];
    int m_exp   [N];
    int m_seq   [N];
    int m_errp  [N];
    int m_err   [N];
    int m_errc  [N];
    int m_wrap  [N];
    int m_term  [N];

    int n_compared   = 0;
    int n_mismatched = 0;
    int cnt          = 0;
    int cyc          = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_dut
            localparam int EW = (gi == 2) ? 2 : 8;
            localparam bit SP = (gi == 1) ? 1'b0 : 1'b1;

            counter_sequence_checker_if #(.WIDTH(4), .ERR_CNT_W(EW)) bus ();

            assign bus.enable     = enable;
            assign bus.counter_in = counter_in;

            assign obs_expected[gi]    = bus.expected;
            assign obs_seq_ok[gi]      = bus.seq_ok;
            assign obs_error_pulse[gi] = bus.error_pulse;
            assign obs_error[gi]       = bus.error;
            assign obs_error_count[gi] = 8'(bus.error_count);
            assign obs_wrap_count[gi]  = bus.wrap_count;
            assign obs_terminal[gi]    = bus.terminal;
            assign obs_state[gi]       = bus.state;

            counter_sequence_checker #(
                .WIDTH(4),
                .ERR_CNT_W(EW),
                .TERMINAL(4'hF),
                .STOP_ON_TERMINAL(SP)
            ) dut (
                .clock(clock),
                .reset(reset),
                .bus(bus)
            );
        end
    endgenerate

    task automatic check(input string tag, input int got, input int want);
        n_compared++;
        if (got != want) begin
            n_mismatched++;
            $display("FAIL %s: got %0d, want %0d (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    // Behavioural reference: state numbers 0 idle, 1 track, 2 fault, 3 done.
    task automatic model_step(input int i, input int r, input int e, input int c);
        int nst;
        int match;
        if (r != 0) begin
            m_state[i] = 0; m_exp[i] = 0; m_seq[i] = 0; m_errp[i] = 0;
            m_err[i] = 0; m_errc[i] = 0; m_wrap[i] = 0; m_term[i] = 0;
            return;
        end
        if (m_state[i] == 3) begin
            m_errp[i] = 0;
            m_term[i] = 0;
            return;
        end
        match = (c == m_exp[i]) ? 1 : 0;
        m_errp[i] = 1 - match;
        m_term[i] = 0;
        if (match == 0) begin
            m_err[i] = 1;
            if (m_errc[i] < err_max[i]) m_errc[i] = m_errc[i] + 1;
        end
        if (m_state[i] == 0) begin
            nst      = (e != 0) ? 1 : 0;
            m_exp[i] = (m_exp[i] + e) % 16;
        end else begin
            nst      = (match != 0) ? 1 : 2;
            m_exp[i] = (c + e) % 16;
            if (m_state[i] == 1 && match != 0 && c == 15) begin
                m_term[i] = 1;
                m_wrap[i] = (m_wrap[i] + 1) % 256;
                if (stop_p[i] != 0) nst = 3;
            end
        end
        m_seq[i]   = (match != 0 && (nst == 1 || nst == 3)) ? 1 : 0;
        m_state[i] = nst;
    endtask

    // One clock: apply inputs, advance the counter and model, compare all outputs.
    task automatic step(input int r, input int e, input int c);
        reset      = (r != 0);
        enable     = (e != 0);
        counter_in = 4'(c);
        @(posedge clock);
        cyc++;
        for (int i = 0; i < N; i++) model_step(i, r, e, c);
        if (r != 0) cnt = 0;
        else if (e != 0) cnt = (cnt + 1) % 16;
        #1;
        for (int i = 0; i < N; i++) begin
            check($sformatf("d%0d.state", i),       obs_state[i],       m_state[i]);
            check($sformatf("d%0d.expected", i),    obs_expected[i],    m_exp[i]);
            check($sformatf("d%0d.seq_ok", i),      obs_seq_ok[i],      m_seq[i]);
            check($sformatf("d%0d.error_pulse", i), obs_error_pulse[i], m_errp[i]);
            check($sformatf("d%0d.error", i),       obs_error[i],       m_err[i]);
            check($sformatf("d%0d.error_count", i), obs_error_count[i], m_errc[i]);
            check($sformatf("d%0d.wrap_count", i),  obs_wrap_count[i],  m_wrap[i]);
            check($sformatf("d%0d.terminal", i),    obs_terminal[i],    m_term[i]);
        end
        $display("cyc %0d rst=%0d en=%0d cin=%0d | st=%0d/%0d/%0d exp=%0d errc=%0d/%0d/%0d wrap=%0d/%0d",
                 cyc, r, e, c, obs_state[0], obs_state[1], obs_state[2], obs_expected[0],
                 obs_error_count[0], obs_error_count[1], obs_error_count[2],
                 obs_wrap_count[0], obs_wrap_count[1]);
    endtask

    // Sample driven from a well-behaved counter.
    task automatic count_step(input int e);
        step(0, e, cnt);
    endtask

    initial begin
        int pattern [7] = '{1, 0, 1, 1, 0, 0, 1};
        int seq3    [7] = '{0, 1, 2, 3, 5, 6, 7};

        reset = 1'b1; enable = 1'b0; counter_in = 4'd0;

        // Reset state
        step(1, 0, 0);
        for (int i = 0; i < N; i++) begin
            check($sformatf("rst.state%0d", i), obs_state[i], 0);
            check($sformatf("rst.expected%0d", i), obs_expected[i], 0);
        end

        // Full count: stop at terminal on d0, wrap twice on d1
        for (int k = 0; k < 40; k++) begin
            count_step(1);
            if (k == 15) begin
                check("t1.terminal", obs_terminal[0], 1);
                check("t1.done", obs_state[0], 3);
                check("t1.seq_ok", obs_seq_ok[0], 1);
            end
        end
        check("t1.errc", obs_error_count[0], 0);
        check("t1.wrap_stop", obs_wrap_count[0], 1);
        check("t4.wrap", obs_wrap_count[1], 2);
        check("t4.state", obs_state[1], 1);
        check("t4.err", obs_error[1], 0);

        // Enable pattern with holds
        step(1, 0, 0);
        for (int k = 0; k < 7; k++) begin
            count_step(pattern[k]);
            check("t2.seq_ok", obs_seq_ok[0], 1);
            check("t2.errp", obs_error_pulse[0], 0);
        end

        // Skipped value 4
        step(1, 0, 0);
        for (int k = 0; k < 7; k++) begin
            step(0, 1, seq3[k]);
            if (k == 4) begin
                check("t3.errp", obs_error_pulse[0], 1);
                check("t3.fault", obs_state[0], 2);
            end
            if (k == 5) check("t3.track", obs_state[0], 1);
        end
        check("t3.err", obs_error[0], 1);
        check("t3.errc", obs_error_count[0], 1);

        // Reset mid-count after an error
        step(1, 0, 0);
        for (int k = 0; k < 5; k++) count_step(1);
        step(0, 1, 9);
        cnt = 6;
        count_step(1);
        step(1, 1, 7);
        check("t5.state", obs_state[0], 0);
        check("t5.expected", obs_expected[0], 0);
        check("t5.err", obs_error[0], 0);
        check("t5.errc", obs_error_count[0], 0);
        count_step(1);
        check("t5.match", obs_seq_ok[0], 1);

        // Stuck counter: saturation of the narrow error counter
        step(1, 0, 0);
        for (int k = 0; k < 5; k++) step(0, 1, 9);
        check("t6.errc_sat", obs_error_count[2], 3);
        check("t6.errc_wide", obs_error_count[0], 5);

        // Randomized traffic with occasional glitches and resets
        step(1, 0, 0);
        for (int k = 0; k < 900; k++) begin
            int r;
            int e;
            int c;
            r = ($urandom_range(0, 59) == 0) ? 1 : 0;
            e = ($urandom_range(0, 3) != 0) ? 1 : 0;
            c = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 15)) : cnt;
            step(r, e, c);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
